ahb_mem_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter with per-master input stages in front of the single-ported instruction/boot memory slave.
- M0 is the core fetch port; M1 is the LSU/debug port.
- An uncontended transfer passes straight through with zero added latency.
- A losing master's address phase is captured, then replayed to the slave when that master wins arbitration.

---
 rtl/ahb_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ahb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-ported memory slave.
// Losing address phases are parked in a per-master pend register and replayed on grant.
module ahb_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  M0_HSEL,
   input  logic [ADDR_WIDTH-1:0] M0_HADDR,
   input  logic [1:0]            M0_HTRANS,
   input  logic                  M0_HWRITE,
   input  logic [2:0]            M0_HSIZE,
   input  logic [31:0]           M0_HWDATA,
   output logic                  M0_HREADY,
   output logic [31:0]           M0_HRDATA,
   output logic [1:0]            M0_HRESP,
   input  logic                  M1_HSEL,
   input  logic [ADDR_WIDTH-1:0] M1_HADDR,
   input  logic [1:0]            M1_HTRANS,
   input  logic                  M1_HWRITE,
   input  logic [2:0]            M1_HSIZE,
   input  logic [31:0]           M1_HWDATA,
   output logic                  M1_HREADY,
   output logic [31:0]           M1_HRDATA,
   output logic [1:0]            M1_HRESP,
   output logic                  S_HSEL,
   output logic [ADDR_WIDTH-1:0] S_HADDR,
   output logic [1:0]            S_HTRANS,
   output logic                  S_HWRITE,
   output logic [2:0]            S_HSIZE,
   output logic [31:0]           S_HWDATA,
   output logic                  S_HREADY,
   input  logic                  S_HREADYOUT,
   input  logic [31:0]           S_HRDATA,
   input  logic [1:0]            S_HRESP
);

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} st_e;

   st_e                  state_q [2];
   st_e                  state_d [2];
   logic [ADDR_WIDTH-1:0] pend_addr_q [2];
   logic [ADDR_WIDTH-1:0] pend_addr_d [2];
   logic [1:0]           pend_trans_q [2];
   logic [1:0]           pend_trans_d [2];
   logic [2:0]           pend_size_q [2];
   logic [2:0]           pend_size_d [2];
   logic [1:0]           pend_write_q, pend_write_d;
   logic                 owner_q, owner_d;
   logic                 owner_valid_q, owner_valid_d;
   logic                 last_grant_q, last_grant_d;

   logic [1:0]           m_sel, m_write;
   logic [ADDR_WIDTH-1:0] m_addr [2];
   logic [1:0]           m_trans [2];
   logic [2:0]           m_size [2];

   logic [1:0]           hready, req, cand;
   logic                 win, win_valid, commit, src_pend;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [1:0]           src_trans;
   logic [2:0]           src_size;
   logic                 src_write;

   assign m_sel     = {M1_HSEL, M0_HSEL};
   assign m_write   = {M1_HWRITE, M0_HWRITE};
   assign m_addr[0] = M0_HADDR;
   assign m_addr[1] = M1_HADDR;
   assign m_trans[0] = M0_HTRANS;
   assign m_trans[1] = M1_HTRANS;
   assign m_size[0] = M0_HSIZE;
   assign m_size[1] = M1_HSIZE;

   always_comb begin
      hready = 2'b11;
      req    = 2'b00;
      cand   = 2'b00;
      for (int n = 0; n < 2; n++) begin
         if (state_q[n] == ST_PEND)      hready[n] = 1'b0;
         else if (state_q[n] == ST_DATA) hready[n] = S_HREADYOUT;
         req[n]  = m_sel[n] & m_trans[n][1] & hready[n];
         cand[n] = (state_q[n] == ST_PEND) | req[n];
      end
   end

   // With both masters contending, round-robin hands the grant to whoever did not win last.
   always_comb begin
      win_valid = |cand;
      win       = (cand == 2'b11) ? (FIXED_PRIO ? 1'b0 : ~last_grant_q) : cand[1];
      commit    = S_HREADYOUT & win_valid & ~HRESET;
      src_pend  = (state_q[win] == ST_PEND);
      src_addr  = src_pend ? pend_addr_q[win]  : m_addr[win];
      src_trans = src_pend ? pend_trans_q[win] : m_trans[win];
      src_size  = src_pend ? pend_size_q[win]  : m_size[win];
      src_write = src_pend ? pend_write_q[win] : m_write[win];
   end

   always_comb begin
      pend_write_d  = pend_write_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      last_grant_d  = last_grant_q;
      for (int n = 0; n < 2; n++) begin
         state_d[n]      = state_q[n];
         pend_addr_d[n]  = pend_addr_q[n];
         pend_trans_d[n] = pend_trans_q[n];
         pend_size_d[n]  = pend_size_q[n];
         if (commit && (win == 1'(n))) begin
            state_d[n] = ST_DATA;
         end else if (req[n]) begin
            state_d[n]      = ST_PEND;
            pend_addr_d[n]  = m_addr[n];
            pend_trans_d[n] = m_trans[n];
            pend_size_d[n]  = m_size[n];
            pend_write_d[n] = m_write[n];
         end else if (S_HREADYOUT && (state_q[n] == ST_DATA)) begin
            state_d[n] = ST_IDLE;
         end
      end
      if (commit) begin
         owner_d       = win;
         owner_valid_d = 1'b1;
         last_grant_d  = win;
      end else if (S_HREADYOUT && !win_valid) begin
         owner_valid_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int n = 0; n < 2; n++) begin
            state_q[n]      <= ST_IDLE;
            pend_addr_q[n]  <= '0;
            pend_trans_q[n] <= 2'b00;
            pend_size_q[n]  <= 3'd0;
         end
         pend_write_q  <= 2'b00;
         owner_q       <= 1'b0;
         owner_valid_q <= 1'b0;
         last_grant_q  <= 1'b1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            state_q[n]      <= state_d[n];
            pend_addr_q[n]  <= pend_addr_d[n];
            pend_trans_q[n] <= pend_trans_d[n];
            pend_size_q[n]  <= pend_size_d[n];
         end
         pend_write_q  <= pend_write_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         last_grant_q  <= last_grant_d;
      end
   end

   // Any active transfer type is forwarded as NONSEQ; bursts are not kept intact.
   assign S_HSEL    = commit;
   assign S_HTRANS  = (commit && (src_trans != 2'b00)) ? 2'b10 : 2'b00;
   assign S_HADDR   = src_addr;
   assign S_HWRITE  = src_write;
   assign S_HSIZE   = src_size;
   assign S_HWDATA  = owner_valid_q ? (owner_q ? M1_HWDATA : M0_HWDATA) : 32'h0;
   assign S_HREADY  = S_HREADYOUT;

   assign M0_HREADY = hready[0];
   assign M1_HREADY = hready[1];
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;
   assign M0_HRESP  = S_HRESP;
   assign M1_HRESP  = S_HRESP;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Bench for ahb_mem_arbiter: per-cycle vector table plus a read-data scoreboard per master,
// with a small memory slave model behind the arbiter.
module tb_ahb_mem_arbiter;

   logic        clk = 1'b0;
   logic        HRESET;
   logic        M0_HSEL, M0_HWRITE, M0_HREADY;
   logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
   logic [1:0]  M0_HTRANS, M0_HRESP;
   logic [2:0]  M0_HSIZE;
   logic        M1_HSEL, M1_HWRITE, M1_HREADY;
   logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
   logic [1:0]  M1_HTRANS, M1_HRESP;
   logic [2:0]  M1_HSIZE;
   logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   logic [1:0]  S_HTRANS, S_HRESP;
   logic [2:0]  S_HSIZE;

   always #5 clk = ~clk;

   ahb_mem_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
      .HCLK(clk), .HRESET(HRESET),
      .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
      .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
      .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
      .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
      .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
      .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
      .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
      .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
      .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP)
   );

   function automatic logic [31:0] pat(int i);
      return 32'hA500_0000 | 32'(i * 4);
   endfunction

   // Memory slave model: one-cycle data phase, stretched while S_HREADYOUT is low.
   logic [31:0] mem [256];
   logic        dp_v, dp_w;
   logic [7:0]  dp_a;
   logic        rdy;

   assign S_HREADYOUT = rdy;
   assign S_HRDATA    = mem[dp_a];
   assign S_HRESP     = 2'b00;

   always @(posedge clk) begin
      if (HRESET) begin
         dp_v <= 1'b0;
         dp_w <= 1'b0;
         dp_a <= 8'd0;
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (S_HREADY) begin
         if (dp_v && dp_w) mem[dp_a] <= S_HWDATA;
         dp_v <= S_HSEL && S_HTRANS[1];
         dp_w <= S_HWRITE;
         dp_a <= S_HADDR[9:2];
      end
   end

   typedef struct {
      logic rst, rdy;
      logic m0r; logic [31:0] m0a; logic m0w;
      logic m1r; logic [31:0] m1a; logic m1w; logic [31:0] m1wd;
      logic e0, e1, es; logic [31:0] ea; logic ew;
      logic cwd, chk;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] ref_mem [256];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [1:0]  dpp, dpr;
   logic [7:0]  dpa [2];
   int          checks = 0;
   int          failures = 0;
   int          row = 0;

   task automatic v(input logic rst, rdy, m0r, input logic [31:0] m0a, input logic m0w,
                    input logic m1r, input logic [31:0] m1a, input logic m1w,
                    input logic [31:0] m1wd, input logic e0, e1, es,
                    input logic [31:0] ea, input logic ew, cwd, chk);
      vec_t t;
      t.rst = rst; t.rdy = rdy; t.m0r = m0r; t.m0a = m0a; t.m0w = m0w;
      t.m1r = m1r; t.m1a = m1a; t.m1w = m1w; t.m1wd = m1wd;
      t.e0 = e0; t.e1 = e1; t.es = es; t.ea = ea; t.ew = ew; t.cwd = cwd; t.chk = chk;
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h exp=%h", nm, row, got, exp);
      end
   endtask

   // Master-side protocol tracking: address accepted when HREADY is high, data phase
   // completes at the next HREADY-high sample.
   task automatic mon(input int n, input logic rq, input logic wr, input logic [31:0] a,
                      input logic hr, input logic [31:0] rdata, input logic [31:0] wd);
      if (dpp[n] && hr) begin
         if (dpr[n]) begin
            if (n == 0 && exp_q0.size() != 0) chk("m0_rdata", rdata, exp_q0.pop_front());
            else if (n == 1 && exp_q1.size() != 0) chk("m1_rdata", rdata, exp_q1.pop_front());
            else begin
               checks++; failures++;
               $display("FAIL m%0d_underflow row=%0d got=data exp=none", n, row);
            end
         end else begin
            ref_mem[dpa[n]] = wd;
         end
         dpp[n] = 1'b0;
      end
      if (rq && hr) begin
         dpp[n] = 1'b1;
         dpr[n] = !wr;
         dpa[n] = a[9:2];
         if (!wr) begin
            if (n == 0) exp_q0.push_back(ref_mem[a[9:2]]);
            else        exp_q1.push_back(ref_mem[a[9:2]]);
         end
      end
   endtask

   task automatic drive(input vec_t t, input int i);
      HRESET    = t.rst;
      rdy       = t.rdy;
      M0_HSEL   = t.m0r;
      M0_HTRANS = t.m0r ? ((i % 2 == 1) ? 2'b11 : 2'b10) : 2'b00;
      M0_HADDR  = t.m0r ? t.m0a : $urandom;
      M0_HWRITE = t.m0w;
      M0_HSIZE  = 3'd2;
      M0_HWDATA = $urandom;
      M1_HSEL   = t.m1r;
      M1_HTRANS = t.m1r ? 2'b10 : 2'b00;
      M1_HADDR  = t.m1r ? t.m1a : $urandom;
      M1_HWRITE = t.m1w;
      M1_HSIZE  = 3'd2;
      M1_HWDATA = t.m1wd;
   endtask

   initial begin
      HRESET = 1'b1; rdy = 1'b1;
      M0_HSEL = 0; M0_HTRANS = 0; M0_HADDR = 0; M0_HWRITE = 0; M0_HSIZE = 2; M0_HWDATA = 0;
      M1_HSEL = 0; M1_HTRANS = 0; M1_HADDR = 0; M1_HWRITE = 0; M1_HSIZE = 2; M1_HWDATA = 0;
      dpp = 2'b00; dpr = 2'b00; dpa[0] = 0; dpa[1] = 0;
      //  rst rdy m0r m0a     m0w m1r m1a      m1w m1wd          e0 e1 es ea       ew cwd chk
      v(1, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 0);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(0, 1, 1, 32'h10,  0, 0, 32'h0,   0, 32'h0,         1, 1, 1, 32'h10,  0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(1, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 0);
      v(0, 1, 1, 32'h0,   0, 1, 32'h4,   0, 32'h0,         1, 1, 1, 32'h0,   0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 0, 1, 32'h4,   0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(0, 1, 1, 32'h0,   0, 1, 32'h100, 0, 32'h0,         1, 1, 1, 32'h0,   0, 0, 1);
      v(0, 1, 1, 32'h4,   0, 0, 32'h0,   0, 32'h0,         1, 0, 1, 32'h100, 0, 0, 1);
      v(0, 1, 1, 32'h8,   0, 0, 32'h0,   0, 32'h0,         0, 1, 1, 32'h4,   0, 0, 1);
      v(0, 1, 1, 32'h8,   0, 0, 32'h0,   0, 32'h0,         1, 1, 1, 32'h8,   0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(1, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 0);
      v(0, 1, 1, 32'h40,  0, 1, 32'h20,  1, 32'h0,         1, 1, 1, 32'h40,  0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'hDEADBEEF,  1, 0, 1, 32'h20,  1, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'hDEADBEEF,  1, 1, 0, 32'h0,   0, 1, 1);
      v(0, 1, 1, 32'h20,  0, 0, 32'h0,   0, 32'h0,         1, 1, 1, 32'h20,  0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(0, 1, 1, 32'h30,  0, 0, 32'h0,   0, 32'h0,         1, 1, 1, 32'h30,  0, 0, 1);
      v(0, 0, 0, 32'h0,   0, 1, 32'h34,  0, 32'h0,         0, 1, 0, 32'h0,   0, 0, 1);
      v(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         0, 0, 0, 32'h0,   0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 0, 1, 32'h34,  0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(0, 0, 0, 32'h0,   0, 1, 32'h38,  0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(1, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 0);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);
      v(0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,         1, 1, 0, 32'h0,   0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         row = i;
         @(posedge clk);
         #1;
         drive(vecs[i], i);
         @(negedge clk);
         if (vecs[i].chk) begin
            chk("m0_hready", 32'(M0_HREADY), 32'(vecs[i].e0));
            chk("m1_hready", 32'(M1_HREADY), 32'(vecs[i].e1));
            chk("s_hsel", 32'(S_HSEL), 32'(vecs[i].es));
            chk("s_htrans", 32'(S_HTRANS), vecs[i].es ? 32'd2 : 32'd0);
            chk("m1_hrdata_bcast", M1_HRDATA, S_HRDATA);
            if (vecs[i].es) begin
               chk("s_haddr", S_HADDR, vecs[i].ea);
               chk("s_hwrite", 32'(S_HWRITE), 32'(vecs[i].ew));
               chk("s_hsize", 32'(S_HSIZE), 32'd2);
            end
            if (vecs[i].cwd) chk("s_hwdata", S_HWDATA, vecs[i].m1wd);
         end
         if (vecs[i].rst) begin
            dpp = 2'b00;
            exp_q0.delete();
            exp_q1.delete();
            for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
         end else begin
            mon(0, vecs[i].m0r, vecs[i].m0w, vecs[i].m0a, M0_HREADY, M0_HRDATA, M0_HWDATA);
            mon(1, vecs[i].m1r, vecs[i].m1w, vecs[i].m1a, M1_HREADY, M1_HRDATA, M1_HWDATA);
         end
      end
      row = vecs.size();
      chk("m0_queue_left", 32'(exp_q0.size()), 32'd0);
      chk("m1_queue_left", 32'(exp_q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
